// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg : shared constants, state encoding and GF(2^8) helper for the    |
// |           AES-128 key-schedule controller.        Revision: 1.0          |
// +--------------------------------------------------------------------------+
package aes_pkg;

  localparam int         NR    = 10;
  localparam int         IDXW  = 4;
  localparam int         RK_W  = 128;
  localparam logic [7:0] RCON0 = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_subword.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_subword : combinational SubWord, four parallel AES S-boxes on a      |
// |               32-bit word.                        Revision: 1.0          |
// +--------------------------------------------------------------------------+
module aes_subword (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_key_schedule_ctrl : iterative AES-128 key expansion into a round-key |
// |                         file with an overlapping read port. Rev: 1.0     |
// +--------------------------------------------------------------------------+
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RK_W-1:0] key,
  output logic            busy,
  output logic            done,
  input  logic            rk_req,
  input  logic [IDXW-1:0] rk_idx,
  output logic            rk_valid,
  output logic [RK_W-1:0] rk,
  output logic            rk_err
);

  localparam int              AVW      = IDXW + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

  state_e          state_q;
  logic [AVW-1:0]  avail_q;
  logic [7:0]      rcon_q;
  logic            busy_q, done_q, rk_valid_q, rk_err_q;
  logic [RK_W-1:0] rk_q;
  logic [RK_W-1:0] file_q [NR+1];

  logic            load_d;
  logic [IDXW-1:0] wr_idx_d, prev_idx_d;
  logic [RK_W-1:0] prev_d, next_d;
  logic [31:0]     rot_d, sub_d, t_d, n0_d, n1_d, n2_d, n3_d;

  assign load_d     = start && (state_q == IDLE || state_q == READY);
  assign wr_idx_d   = avail_q[IDXW-1:0];
  assign prev_idx_d = wr_idx_d - IDXW'(1);
  assign prev_d     = file_q[prev_idx_d];

  assign rot_d = {prev_d[103:96], prev_d[127:104]};

  aes_subword u_subword (
    .word_i (rot_d),
    .word_o (sub_d)
  );

  // Whole next round key resolves in one cycle from the previous entry.
  assign t_d    = {sub_d[31:8], sub_d[7:0] ^ rcon_q};
  assign n0_d   = prev_d[31:0]   ^ t_d;
  assign n1_d   = prev_d[63:32]  ^ n0_d;
  assign n2_d   = prev_d[95:64]  ^ n1_d;
  assign n3_d   = prev_d[127:96] ^ n2_d;
  assign next_d = {n3_d, n2_d, n1_d, n0_d};

  always_ff @(posedge clk) begin
    if (load_d) begin
      file_q[0] <= key;
    end else if (state_q == EXPAND) begin
      file_q[wr_idx_d] <= next_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      avail_q    <= '0;
      rcon_q     <= RCON0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, READY: begin
          if (start) begin
            state_q <= EXPAND;
            avail_q <= AVW'(1);
            rcon_q  <= RCON0;
            busy_q  <= 1'b1;
          end
        end
        EXPAND: begin
          avail_q <= avail_q + AVW'(1);
          rcon_q  <= xtime(rcon_q);
          if (wr_idx_d == LAST_IDX) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Entries at or above avail are stale or unwritten, so the read waits.
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      if (rk_req) begin
        if (rk_idx > LAST_IDX) begin
          rk_valid_q <= 1'b1;
          rk_err_q   <= 1'b1;
          rk_q       <= '0;
        end else if ({1'b0, rk_idx} < avail_q) begin
          rk_valid_q <= 1'b1;
          rk_q       <= file_q[rk_idx];
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_err   = rk_err_q;
  assign rk       = rk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes_key_schedule_ctrl : directed self-checking bench for the AES-128  |
// |                            key-schedule controller.    Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_aes_key_schedule_ctrl;
  import aes_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [RK_W-1:0] key;
  logic            busy, done;
  logic            rk_req;
  logic [IDXW-1:0] rk_idx;
  logic            rk_valid;
  logic [RK_W-1:0] rk;
  logic            rk_err;

  int checks = 0;
  int errors = 0;

  // FIPS-197 A.1 round keys in FIPS byte order; byte-reversed before use.
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] z_rk1  = {4{32'h63636362}};
  logic [127:0] z_rk2_fips = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  logic [127:0] z_rk10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  always #5 clk = ~clk;

  aes_key_schedule_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .rk_req   (rk_req),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_err   (rk_err)
  );

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // lat = edges until rk_valid seen, 0 if the bound expired.
  task automatic read_rk(input logic [IDXW-1:0] idx, output logic [127:0] d,
                         output logic e, output int lat);
    rk_req = 1'b1;
    rk_idx = idx;
    lat = 0; d = '0; e = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (rk_valid === 1'b1) begin
        lat = c; d = rk; e = rk_err;
        break;
      end
    end
    rk_req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int vcnt;
    rst = 1'b1; start = 1'b0; key = '0; rk_req = 1'b0; rk_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rk_valid !== 1'b0 || rk_err !== 1'b0) begin
      errors++; $display("FAIL reset_valid_err got %b/%b want 0/0", rk_valid, rk_err); end
    checks++; if (rk !== '0) begin errors++; $display("FAIL reset_rk got %h want 0", rk); end
    rk_req = 1'b1; rk_idx = '0; vcnt = 0;
    for (int c = 0; c < 3; c++) begin step(); if (rk_valid === 1'b1) vcnt++; end
    rk_req = 1'b0;
    checks++; if (vcnt != 0) begin errors++; $display("FAIL reset_unreadable got %0d valids want 0", vcnt); end
  endtask

  task automatic test_zero_key();
    int bcnt, dcnt, dat, lat;
    logic [127:0] d;
    logic e;
    do_start('0);
    bcnt = 0; dcnt = 0; dat = -1;
    for (int c = 0; c < 15; c++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin dcnt++; dat = c; end
      step();
    end
    checks++; if (bcnt != 10) begin errors++; $display("FAIL zero_busy_cycles got %0d want 10", bcnt); end
    checks++; if (dcnt != 1 || dat != 10) begin
      errors++; $display("FAIL zero_done_pulse got count %0d at %0d want 1 at 10", dcnt, dat); end
    read_rk(4'd1, d, e, lat);
    checks++; if (d !== z_rk1 || lat != 1) begin
      errors++; $display("FAIL zero_rk1 got %h lat %0d want %h lat 1", d, lat, z_rk1); end
    read_rk(4'd2, d, e, lat);
    checks++; if (d !== brev(z_rk2_fips)) begin
      errors++; $display("FAIL zero_rk2 got %h want %h", d, brev(z_rk2_fips)); end
    read_rk(4'd10, d, e, lat);
    checks++; if (d !== z_rk10 || e !== 1'b0) begin
      errors++; $display("FAIL zero_rk10 got %h err %b want %h err 0", d, e, z_rk10); end
  endtask

  task automatic test_fips_stall();
    int lat, n;
    logic [127:0] d;
    logic e;
    do_start(brev(fips_rk[0]));
    read_rk(4'd5, d, e, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL stall_idx5_latency got %0d want 6", lat); end
    checks++; if (d !== brev(fips_rk[5])) begin
      errors++; $display("FAIL stall_idx5_data got %h want %h", d, brev(fips_rk[5])); end
    wait_done(n);
    checks++; if (n != 4) begin errors++; $display("FAIL fips_done_timing got %0d want 4", n); end
    read_rk(4'd10, d, e, lat);
    checks++; if (d !== brev(fips_rk[10])) begin
      errors++; $display("FAIL fips_rk10 got %h want %h", d, brev(fips_rk[10])); end
    read_rk(4'd0, d, e, lat);
    checks++; if (d !== brev(fips_rk[0])) begin
      errors++; $display("FAIL fips_rk0 got %h want %h", d, brev(fips_rk[0])); end
  endtask

  task automatic test_range_back_to_back();
    int lat, pulses;
    logic [127:0] d;
    logic e;
    read_rk(4'd11, d, e, lat);
    checks++; if (lat != 1 || e !== 1'b1 || d !== '0) begin
      errors++; $display("FAIL range_idx11 got lat %0d err %b rk %h want 1 1 0", lat, e, d); end
    rk_req = 1'b1; rk_idx = '0; pulses = 0;
    for (int i = 0; i <= 10; i++) begin
      step();
      if (rk_valid === 1'b1) pulses++;
      checks++; if (rk_valid !== 1'b1 || rk_err !== 1'b0 || rk !== brev(fips_rk[i])) begin
        errors++; $display("FAIL b2b_idx%0d got v%b e%b %h want v1 e0 %h", i, rk_valid, rk_err, rk,
                           brev(fips_rk[i])); end
      rk_idx = IDXW'(i + 1);
    end
    rk_req = 1'b0;
    checks++; if (pulses != 11) begin errors++; $display("FAIL b2b_pulses got %0d want 11", pulses); end
    step();
    checks++; if (rk_valid !== 1'b0 || rk !== brev(fips_rk[10])) begin
      errors++; $display("FAIL idle_hold got v%b %h want v0 %h", rk_valid, rk, brev(fips_rk[10])); end
  endtask

  task automatic test_restart();
    int lat, n;
    logic [127:0] d;
    logic e;
    do_start('0);
    step(); step();
    key = brev(fips_rk[0]); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    checks++; if (n != 7) begin errors++; $display("FAIL ignored_start_done got %0d want 7", n); end
    read_rk(4'd10, d, e, lat);
    checks++; if (d !== z_rk10) begin errors++; $display("FAIL ignored_start_rk10 got %h want %h", d, z_rk10); end
    read_rk(4'd0, d, e, lat);
    checks++; if (d !== '0) begin errors++; $display("FAIL ignored_start_rk0 got %h want 0", d); end
    do_start(brev(fips_rk[0]));
    read_rk(4'd3, d, e, lat);
    checks++; if (lat != 4 || d !== brev(fips_rk[3])) begin
      errors++; $display("FAIL restart_idx3 got lat %0d %h want lat 4 %h", lat, d, brev(fips_rk[3])); end
    wait_done(n);
    checks++; if (n == 0) begin errors++; $display("FAIL restart_done got timeout want pulse"); end
  endtask

  task automatic test_reset_mid_expand();
    int lat, n, vcnt;
    logic [127:0] d;
    logic e;
    do_start('0);
    step(); step(); step();
    rk_req = 1'b1; rk_idx = 4'd9;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_busy_done got %b/%b want 0/0", busy, done); end
    checks++; if (rk_valid !== 1'b0 || rk_err !== 1'b0 || rk !== '0) begin
      errors++; $display("FAIL midrst_read got v%b e%b %h want 0 0 0", rk_valid, rk_err, rk); end
    step();
    rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 3; c++) begin step(); if (rk_valid === 1'b1) vcnt++; end
    rk_req = 1'b0;
    checks++; if (vcnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_dropped got %0d valids busy %b want 0 0", vcnt, busy); end
    do_start(brev(fips_rk[0]));
    read_rk(4'd1, d, e, lat);
    checks++; if (lat != 2 || d !== brev(fips_rk[1])) begin
      errors++; $display("FAIL fresh_rk1 got lat %0d %h want lat 2 %h", lat, d, brev(fips_rk[1])); end
    wait_done(n);
    read_rk(4'd10, d, e, lat);
    checks++; if (n == 0 || d !== brev(fips_rk[10])) begin
      errors++; $display("FAIL fresh_rk10 got done %0d %h want %h", n, d, brev(fips_rk[10])); end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_fips_stall();
    test_range_back_to_back();
    test_restart();
    test_reset_mid_expand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
